// File: rtl/key_pkg.sv
// Shared types and helpers for the key click classifier.
package key_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } click_state_t;

    // Number of clock cycles spanning a time window given in microseconds.
    function automatic int win_cycles(input int mhz, input int us);
        return mhz * us;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous show-ahead FIFO holding completed click-burst events.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module key_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Accepted push/pop and next pointer values.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/key_click_classifier.sv
// Groups debounced key strobes into click bursts and queues one event
// (the click count) per burst. A burst closes on window timeout or when
// it reaches MAX_CLICKS.
module key_click_classifier
    import key_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 50,
    parameter int WINDOW_US      = 250000,
    parameter int MAX_CLICKS     = 3,
    parameter int EVT_FIFO_DEPTH = 4,
    localparam int WINDOW_CYC    = win_cycles(CLK_FREQ_MHZ, WINDOW_US),
    localparam int TMR_W         = $clog2(WINDOW_CYC) + 1,
    localparam int CLK_W         = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_stb_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CLK_W-1:0] evt_clicks_o,
    output logic             busy_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i
);

    localparam logic [CLK_W-1:0] MAX_C     = CLK_W'(MAX_CLICKS);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(WINDOW_CYC - 1);

    click_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CLK_W-1:0] clicks_q, clicks_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic [CLK_W-1:0] push_clicks;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign evt_valid_o = ~fifo_empty;
    assign pop         = evt_valid_o & evt_ready_i;
    assign busy_o      = (state_q == COUNT);
    assign ovf_o       = ovf_q;

    // Burst FSM: a strobe on the timeout cycle extends the burst.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        clicks_d    = clicks_q;
        push        = 1'b0;
        push_clicks = '0;
        case (state_q)
            IDLE: begin
                if (key_stb_i) begin
                    state_d  = COUNT;
                    clicks_d = CLK_W'(1);
                    timer_d  = '0;
                end
            end
            COUNT: begin
                if (key_stb_i) begin
                    if (clicks_q + CLK_W'(1) == MAX_C) begin
                        push        = 1'b1;
                        push_clicks = MAX_C;
                        state_d     = IDLE;
                        clicks_d    = '0;
                        timer_d     = '0;
                    end else begin
                        clicks_d = clicks_q + CLK_W'(1);
                        timer_d  = '0;
                    end
                end else if (timer_q == LAST_TICK) begin
                    push        = 1'b1;
                    push_clicks = clicks_q;
                    state_d     = IDLE;
                    clicks_d    = '0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow: a dropped event beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full && !evt_ready_i) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; reset mid-burst silently discards the burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            clicks_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            clicks_q <= clicks_d;
            ovf_q    <= ovf_d;
        end
    end

    key_evt_fifo #(
        .WIDTH (CLK_W),
        .DEPTH (EVT_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_clicks),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .empty_o (fifo_empty),
        .rdata_o (evt_clicks_o)
    );

endmodule
